// File: rtl/pdp11_trace_monitor_if.sv
// Bus bundle between the pdp11 cpu/host side and the trace monitor:
// cpu observation, comparator programming, capture control and readout.
interface pdp11_trace_monitor_if #(
    parameter int DEPTH    = 64,
    parameter int NTRIG    = 4,
    parameter int ISTATE_W = 5,
    parameter int TO_W     = 32
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (NTRIG > 1) ? $clog2(NTRIG) : 1;

    logic [ISTATE_W-1:0] istate;
    logic [15:0]         pc;
    logic [15:0]         isn;
    logic                trig_wr;
    logic [TW-1:0]       trig_sel;
    logic [15:0]         trig_pc;
    logic                trig_en;
    logic                arm;
    logic                mode;
    logic [AW:0]         post_count;
    logic [TO_W-1:0]     timeout;
    logic                rd_en;
    logic [15:0]         rd_pc;
    logic [15:0]         rd_isn;
    logic                rd_valid;
    logic [AW:0]         count;
    logic [1:0]          state;
    logic [NTRIG-1:0]    trig_hit;
    logic                halt_seen;
    logic                timeout_hit;
    logic [31:0]         cycles;

    modport master (
        output istate, pc, isn, trig_wr, trig_sel, trig_pc, trig_en,
               arm, mode, post_count, timeout, rd_en,
        input  rd_pc, rd_isn, rd_valid, count, state, trig_hit,
               halt_seen, timeout_hit, cycles
    );

    modport slave (
        input  istate, pc, isn, trig_wr, trig_sel, trig_pc, trig_en,
               arm, mode, post_count, timeout, rd_en,
        output rd_pc, rd_isn, rd_valid, count, state, trig_hit,
               halt_seen, timeout_hit, cycles
    );
endinterface

// File: rtl/pdp11_trace_monitor.sv
// PDP-11 instruction trace monitor: records fetched pc/isn pairs into a
// circular buffer, gated by PC comparators, a halt detector and a watchdog.
module pdp11_trace_monitor #(
    parameter int                  DEPTH    = 64,
    parameter int                  NTRIG    = 4,
    parameter int                  ISTATE_W = 5,
    parameter logic [ISTATE_W-1:0] FETCH_ST = ISTATE_W'(1),
    parameter logic [ISTATE_W-1:0] HALT_ST  = ISTATE_W'(0),
    parameter int                  TO_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pdp11_trace_monitor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   prev_fetch_q, prev_fetch_d;
    logic [NTRIG-1:0][15:0] trig_pc_q, trig_pc_d;
    logic [NTRIG-1:0]       trig_en_q, trig_en_d;
    logic                   mode_q, mode_d;
    logic [AW:0]            post_q, post_d;
    logic [AW:0]            post_cnt_q, post_cnt_d;
    logic [TO_W-1:0]        wd_q, wd_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [15:0]            rd_pc_q, rd_pc_d;
    logic [15:0]            rd_isn_q, rd_isn_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [NTRIG-1:0]       trig_hit_q, trig_hit_d;
    logic                   halt_seen_q, halt_seen_d;
    logic                   timeout_hit_q, timeout_hit_d;
    logic [31:0]            cycles_q, cycles_d;

    logic [31:0]            buf_mem [DEPTH];
    logic                   fetch_ev;
    logic [NTRIG-1:0]       match_vec;
    logic                   record;

    assign fetch_ev = (bus.istate == FETCH_ST) && !prev_fetch_q;

    // Comparator match vector for this cycle's fetch, using the comparator values already stored
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NTRIG; i++) begin
            match_vec[i] = fetch_ev && trig_en_q[i] && (bus.pc == trig_pc_q[i]);
        end
    end

    // Capture FSM, comparator programming, buffer pointer bookkeeping and readout
    always_comb begin
        state_d       = state_q;
        prev_fetch_d  = (bus.istate == FETCH_ST);
        trig_pc_d     = trig_pc_q;
        trig_en_d     = trig_en_q;
        mode_d        = mode_q;
        post_d        = post_q;
        post_cnt_d    = post_cnt_q;
        wd_d          = wd_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rd_pc_d       = rd_pc_q;
        rd_isn_d      = rd_isn_q;
        rd_valid_d    = 1'b0;
        trig_hit_d    = trig_hit_q;
        halt_seen_d   = halt_seen_q;
        timeout_hit_d = timeout_hit_q;
        cycles_d      = cycles_q + 32'd1;
        record        = 1'b0;

        if (bus.trig_wr && (32'(bus.trig_sel) < NTRIG)) begin
            trig_pc_d[bus.trig_sel] = bus.trig_pc;
            trig_en_d[bus.trig_sel] = bus.trig_en;
        end

        if (bus.arm) begin
            state_d       = ST_ARMED;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            trig_hit_d    = '0;
            halt_seen_d   = 1'b0;
            timeout_hit_d = 1'b0;
            wd_d          = '0;
            mode_d        = bus.mode;
            post_d        = bus.post_count;
        end else begin
            case (state_q)
                ST_ARMED, ST_CAPTURE: begin
                    wd_d = wd_q + TO_W'(1);
                    if (bus.istate == HALT_ST) begin
                        halt_seen_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if ((bus.timeout != '0) && (wd_q == bus.timeout - TO_W'(1))) begin
                        timeout_hit_d = 1'b1;
                        state_d       = ST_DONE;
                    end else if (state_q == ST_ARMED) begin
                        if (!mode_q) begin
                            if (|match_vec) begin
                                record     = 1'b1;
                                trig_hit_d = match_vec;
                                state_d    = ST_CAPTURE;
                            end
                        end else if (fetch_ev) begin
                            record = 1'b1;
                            if (|match_vec) begin
                                trig_hit_d = match_vec;
                                if (post_q == '0) begin
                                    state_d = ST_DONE;
                                end else begin
                                    post_cnt_d = post_q;
                                    state_d    = ST_CAPTURE;
                                end
                            end
                        end
                    end else if (fetch_ev) begin
                        record = 1'b1;
                        if (!mode_q) begin
                            if (count_q == LAST_CNT) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            post_cnt_d = post_cnt_q - ONE_CNT;
                            if (post_cnt_q == ONE_CNT) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.rd_en && (count_q != '0)) begin
                        rd_pc_d    = buf_mem[rd_ptr_q][31:16];
                        rd_isn_d   = buf_mem[rd_ptr_q][15:0];
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + AW'(1);
                        count_d    = count_q - ONE_CNT;
                    end
                end
                default: ;
            endcase
        end

        if (record) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q == FULL_CNT) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                count_d = count_q + ONE_CNT;
            end
        end
    end

    // Trace storage: plain RAM, contents are meaningless until written after arm
    always_ff @(posedge clk) begin
        if (record) begin
            buf_mem[wr_ptr_q] <= {bus.pc, bus.isn};
        end
    end

    // State register with asynchronous clear of all control and status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            prev_fetch_q  <= 1'b0;
            trig_pc_q     <= '0;
            trig_en_q     <= '0;
            mode_q        <= 1'b0;
            post_q        <= '0;
            post_cnt_q    <= '0;
            wd_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_pc_q       <= '0;
            rd_isn_q      <= '0;
            rd_valid_q    <= 1'b0;
            trig_hit_q    <= '0;
            halt_seen_q   <= 1'b0;
            timeout_hit_q <= 1'b0;
            cycles_q      <= '0;
        end else begin
            state_q       <= state_d;
            prev_fetch_q  <= prev_fetch_d;
            trig_pc_q     <= trig_pc_d;
            trig_en_q     <= trig_en_d;
            mode_q        <= mode_d;
            post_q        <= post_d;
            post_cnt_q    <= post_cnt_d;
            wd_q          <= wd_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rd_pc_q       <= rd_pc_d;
            rd_isn_q      <= rd_isn_d;
            rd_valid_q    <= rd_valid_d;
            trig_hit_q    <= trig_hit_d;
            halt_seen_q   <= halt_seen_d;
            timeout_hit_q <= timeout_hit_d;
            cycles_q      <= cycles_d;
        end
    end

    assign bus.rd_pc       = rd_pc_q;
    assign bus.rd_isn      = rd_isn_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.count       = count_q;
    assign bus.state       = state_q;
    assign bus.trig_hit    = trig_hit_q;
    assign bus.halt_seen   = halt_seen_q;
    assign bus.timeout_hit = timeout_hit_q;
    assign bus.cycles      = cycles_q;
endmodule

// File: tb/tb_pdp11_trace_monitor.sv
// Testbench for pdp11_trace_monitor: drives a fetch stream, keeps a
// scoreboard of entries that should be captured and checks the readout.
module tb_pdp11_trace_monitor;
    localparam int DEPTH    = 64;
    localparam int NTRIG    = 4;
    localparam int ISTATE_W = 5;
    localparam int TO_W     = 32;

    localparam logic [4:0]  IST_FETCH = 5'd1;
    localparam logic [4:0]  IST_HALT  = 5'd0;
    localparam logic [4:0]  IST_OTHER = 5'd2;
    localparam logic [15:0] TRIG_PC   = 16'o137046;

    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_DONE = 2'd3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    pdp11_trace_monitor_if #(.DEPTH(DEPTH), .NTRIG(NTRIG), .ISTATE_W(ISTATE_W), .TO_W(TO_W)) bus ();

    pdp11_trace_monitor #(
        .DEPTH(DEPTH), .NTRIG(NTRIG), .ISTATE_W(ISTATE_W),
        .FETCH_ST(IST_FETCH), .HALT_ST(IST_HALT), .TO_W(TO_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_trig(input int sel, input logic [15:0] pc, input logic en);
        bus.trig_wr  = 1'b1;
        bus.trig_sel = 2'(sel);
        bus.trig_pc  = pc;
        bus.trig_en  = en;
        tick();
        bus.trig_wr  = 1'b0;
    endtask

    task automatic arm_capture(input logic m, input logic [6:0] post, input logic [31:0] to);
        bus.mode       = m;
        bus.post_count = post;
        bus.timeout    = to;
        bus.arm        = 1'b1;
        tick();
        bus.arm        = 1'b0;
        sb.delete();
    endtask

    // One instruction: a fetch cycle followed by a non-fetch cycle; optionally
    // push it to the scoreboard, trimming to DEPTH entries for overwrite mode.
    task automatic apply_fetch(input logic [15:0] pc, input logic expect_rec);
        logic [15:0] isn;
        isn        = 16'($urandom_range(0, 65535));
        bus.istate = IST_FETCH;
        bus.pc     = pc;
        bus.isn    = isn;
        tick();
        bus.istate = IST_OTHER;
        tick();
        if (expect_rec) begin
            sb.push_back({pc, isn});
            if (sb.size() > DEPTH) void'(sb.pop_front());
        end
    endtask

    task automatic halt_cpu();
        bus.istate = IST_HALT;
        tick();
        bus.istate = IST_OTHER;
    endtask

    // Back-to-back pops of every scoreboard entry, then one pop on an empty buffer
    task automatic drain_and_check(input string name);
        int          n;
        logic [31:0] exp_e;
        logic [31:0] last_e;
        n = sb.size();
        last_e = {bus.rd_pc, bus.rd_isn};
        bus.rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_e = sb.pop_front();
            tick();
            checks++;
            if (bus.rd_valid !== 1'b1 || {bus.rd_pc, bus.rd_isn} !== exp_e) begin
                errors++;
                $display("[TB] FAIL %s pop %0d: got valid=%b pc=%o isn=%o, expected pc=%o isn=%o",
                         name, i, bus.rd_valid, bus.rd_pc, bus.rd_isn, exp_e[31:16], exp_e[15:0]);
            end
            checks++;
            if (bus.count !== 7'(n - 1 - i)) begin
                errors++;
                $display("[TB] FAIL %s count after pop %0d: got %0d expected %0d", name, i, bus.count, n - 1 - i);
            end
            last_e = exp_e;
        end
        tick();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b0 || {bus.rd_pc, bus.rd_isn} !== last_e) begin
            errors++;
            $display("[TB] FAIL %s empty pop: got valid=%b data=%h expected valid=0 data=%h",
                     name, bus.rd_valid, {bus.rd_pc, bus.rd_isn}, last_e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.state !== S_IDLE || bus.count !== 7'd0 || bus.rd_valid !== 1'b0 ||
            bus.rd_pc !== 16'd0 || bus.rd_isn !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got state=%0d count=%0d valid=%b pc=%o isn=%o expected all 0",
                     bus.state, bus.count, bus.rd_valid, bus.rd_pc, bus.rd_isn);
        end
        checks++;
        if (bus.trig_hit !== 4'd0 || bus.halt_seen !== 1'b0 || bus.timeout_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset flags: got hit=%b halt=%b to=%b expected 0", bus.trig_hit, bus.halt_seen, bus.timeout_hit);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.cycles !== 32'd5) begin
            errors++;
            $display("[TB] FAIL cycles after reset: got %0d expected 5", bus.cycles);
        end
    endtask

    task automatic test_mode0_halt();
        write_trig(0, TRIG_PC, 1'b1);
        arm_capture(1'b0, 7'd0, 32'd0);
        for (int i = 0; i < 3; i++) apply_fetch(16'o1000 + 16'(2 * i), 1'b0);
        apply_fetch(TRIG_PC, 1'b1);
        checks++;
        if (bus.state !== S_CAPTURE) begin
            errors++;
            $display("[TB] FAIL m0 trigger state: got %0d expected %0d", bus.state, S_CAPTURE);
        end
        for (int i = 0; i < 9; i++) apply_fetch(16'o1100 + 16'(2 * i), 1'b1);
        halt_cpu();
        checks++;
        if (bus.state !== S_DONE || bus.count !== 7'd10 || bus.halt_seen !== 1'b1 || bus.trig_hit !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL m0 halt status: got state=%0d count=%0d halt=%b hit=%b expected 3 10 1 0001",
                     bus.state, bus.count, bus.halt_seen, bus.trig_hit);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        void'(sb.pop_front());
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_pc !== TRIG_PC) begin
            errors++;
            $display("[TB] FAIL m0 first pop: got valid=%b pc=%o expected 1 %o", bus.rd_valid, bus.rd_pc, TRIG_PC);
        end
        drain_and_check("m0_halt");
    endtask

    task automatic test_mode0_full();
        write_trig(2, TRIG_PC, 1'b1);
        arm_capture(1'b0, 7'd0, 32'd0);
        apply_fetch(TRIG_PC, 1'b1);
        for (int i = 0; i < 100; i++) begin
            apply_fetch(16'o2000 + 16'(2 * i), (i < DEPTH - 1));
            if (i == DEPTH - 3) begin
                checks++;
                if (bus.state !== S_CAPTURE || bus.count !== 7'd63) begin
                    errors++;
                    $display("[TB] FAIL m0 one short of full: got state=%0d count=%0d expected 2 63", bus.state, bus.count);
                end
            end
        end
        checks++;
        if (bus.state !== S_DONE || bus.count !== 7'd64 || bus.trig_hit !== 4'b0101 || bus.halt_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL m0 full status: got state=%0d count=%0d hit=%b halt=%b expected 3 64 0101 0",
                     bus.state, bus.count, bus.trig_hit, bus.halt_seen);
        end
        drain_and_check("m0_full");
        write_trig(2, 16'd0, 1'b0);
    endtask

    task automatic test_mode1_post();
        arm_capture(1'b1, 7'd3, 32'd0);
        for (int i = 0; i < 70; i++) apply_fetch(16'o3000 + 16'(2 * i), 1'b1);
        apply_fetch(TRIG_PC, 1'b1);
        checks++;
        if (bus.state !== S_CAPTURE || bus.count !== 7'd64) begin
            errors++;
            $display("[TB] FAIL m1 after trigger: got state=%0d count=%0d expected 2 64", bus.state, bus.count);
        end
        apply_fetch(16'o4000, 1'b1);
        apply_fetch(16'o4002, 1'b1);
        checks++;
        if (bus.state !== S_CAPTURE) begin
            errors++;
            $display("[TB] FAIL m1 post 2 state: got %0d expected %0d", bus.state, S_CAPTURE);
        end
        apply_fetch(16'o4004, 1'b1);
        checks++;
        if (bus.state !== S_DONE || bus.count !== 7'd64 || bus.trig_hit !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL m1 done: got state=%0d count=%0d hit=%b expected 3 64 0001", bus.state, bus.count, bus.trig_hit);
        end
        drain_and_check("m1_post3");
    endtask

    task automatic test_mode1_post_zero();
        arm_capture(1'b1, 7'd0, 32'd0);
        apply_fetch(16'o5000, 1'b1);
        apply_fetch(16'o5002, 1'b1);
        apply_fetch(TRIG_PC, 1'b1);
        checks++;
        if (bus.state !== S_DONE || bus.count !== 7'd3) begin
            errors++;
            $display("[TB] FAIL m1 post0: got state=%0d count=%0d expected 3 3", bus.state, bus.count);
        end
        drain_and_check("m1_post0");
    endtask

    task automatic test_timeout();
        arm_capture(1'b0, 7'd0, 32'd500);
        for (int i = 0; i < 499; i++) tick();
        checks++;
        if (bus.state !== S_ARMED || bus.timeout_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout early: got state=%0d to=%b expected 1 0", bus.state, bus.timeout_hit);
        end
        tick();
        checks++;
        if (bus.state !== S_DONE || bus.timeout_hit !== 1'b1 || bus.count !== 7'd0 || bus.halt_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout expiry: got state=%0d to=%b count=%0d halt=%b expected 3 1 0 0",
                     bus.state, bus.timeout_hit, bus.count, bus.halt_seen);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout empty read: got valid=%b expected 0", bus.rd_valid);
        end
    endtask

    task automatic test_arm_mid_capture();
        arm_capture(1'b0, 7'd0, 32'd0);
        apply_fetch(TRIG_PC, 1'b1);
        apply_fetch(16'o6000, 1'b1);
        apply_fetch(16'o6002, 1'b1);
        checks++;
        if (bus.state !== S_CAPTURE || bus.count !== 7'd3) begin
            errors++;
            $display("[TB] FAIL rearm setup: got state=%0d count=%0d expected 2 3", bus.state, bus.count);
        end
        bus.istate = IST_FETCH;
        bus.pc     = TRIG_PC;
        bus.arm    = 1'b1;
        bus.mode   = 1'b0;
        tick();
        bus.arm    = 1'b0;
        bus.istate = IST_OTHER;
        sb.delete();
        checks++;
        if (bus.state !== S_ARMED || bus.count !== 7'd0 || bus.trig_hit !== 4'd0 || bus.halt_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rearm: got state=%0d count=%0d hit=%b halt=%b expected 1 0 0000 0",
                     bus.state, bus.count, bus.trig_hit, bus.halt_seen);
        end
        halt_cpu();
        checks++;
        if (bus.state !== S_DONE || bus.count !== 7'd0 || bus.halt_seen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rearm halt: got state=%0d count=%0d halt=%b expected 3 0 1", bus.state, bus.count, bus.halt_seen);
        end
    endtask

    task automatic test_reset_mid_readout();
        logic [31:0] exp_e;
        arm_capture(1'b0, 7'd0, 32'd0);
        apply_fetch(TRIG_PC, 1'b1);
        for (int i = 0; i < 4; i++) apply_fetch(16'o7000 + 16'(2 * i), 1'b1);
        halt_cpu();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        exp_e = sb.pop_front();
        checks++;
        if (bus.rd_valid !== 1'b1 || {bus.rd_pc, bus.rd_isn} !== exp_e) begin
            errors++;
            $display("[TB] FAIL pre-reset pop: got valid=%b data=%h expected 1 %h", bus.rd_valid, {bus.rd_pc, bus.rd_isn}, exp_e);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_pc !== 16'd0 || bus.rd_isn !== 16'd0 || bus.count !== 7'd0 ||
            bus.state !== S_IDLE || bus.halt_seen !== 1'b0 || bus.trig_hit !== 4'd0) begin
            errors++;
            $display("[TB] FAIL async reset: got valid=%b pc=%o isn=%o count=%0d state=%0d halt=%b hit=%b expected all 0",
                     bus.rd_valid, bus.rd_pc, bus.rd_isn, bus.count, bus.state, bus.halt_seen, bus.trig_hit);
        end
        #1;
        reset = 1'b0;
        tick();
        arm_capture(1'b0, 7'd0, 32'd0);
        apply_fetch(TRIG_PC, 1'b0);
        checks++;
        if (bus.state !== S_ARMED || bus.count !== 7'd0) begin
            errors++;
            $display("[TB] FAIL comparators after reset: got state=%0d count=%0d expected 1 0", bus.state, bus.count);
        end
    endtask

    initial begin
        bus.istate     = IST_OTHER;
        bus.pc         = '0;
        bus.isn        = '0;
        bus.trig_wr    = 1'b0;
        bus.trig_sel   = '0;
        bus.trig_pc    = '0;
        bus.trig_en    = 1'b0;
        bus.arm        = 1'b0;
        bus.mode       = 1'b0;
        bus.post_count = '0;
        bus.timeout    = '0;
        bus.rd_en      = 1'b0;
        test_reset();
        test_mode0_halt();
        test_mode0_full();
        test_mode1_post();
        test_mode1_post_zero();
        test_timeout();
        test_arm_mid_capture();
        test_reset_mid_readout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
